// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage placed in front of decode. Holds the fetch program
// counter, issues at most one outstanding read to instruction memory, buffers
// returned words in a small in-order queue and presents the queue head to
// decode. A taken branch flushes the queue and restarts fetch at the target;
// a read still in flight at that moment is completed and its data discarded.
//
// Parameters
//   W_INST    instruction width
//   W_ADDR    byte address width
//   DEPTH     instruction queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset (word aligned)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   imem_req_o    read request to instruction memory
//   imem_addr_o   read byte address (held stable while a request is open)
//   imem_ack_i    read complete, imem_data_i valid this cycle
//   imem_data_i   read data
//   br_valid_i    redirect fetch to br_target_i
//   br_target_i   redirect byte address, bits [1:0] ignored
//   stall_i       decode cannot accept the head instruction
//   inst_o        head-of-queue instruction
//   pc_o          byte address of inst_o
//   inst_valid_o  queue non-empty, inst_o/pc_o meaningful
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int                 W_INST   = 32,
    parameter int                 W_ADDR   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [W_ADDR-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_o,
    output logic [W_ADDR-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [W_INST-1:0]  imem_data_i,
    input  logic               br_valid_i,
    input  logic [W_ADDR-1:0]  br_target_i,
    input  logic               stall_i,
    output logic [W_INST-1:0]  inst_o,
    output logic [W_ADDR-1:0]  pc_o,
    output logic               inst_valid_o
);

    localparam int W_PTR = $clog2(DEPTH);
    localparam int W_CNT = W_PTR + 1;
    localparam logic [W_CNT-1:0] C_DEPTH = W_CNT'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DISCARD
    } state_t;

    // State and datapath registers
    state_t              r_state;
    logic [W_ADDR-1:0]   r_addr;
    logic [W_ADDR-1:0]   r_fetch_pc;
    logic [W_CNT-1:0]    r_count;
    logic [W_PTR-1:0]    r_head;
    logic [W_PTR-1:0]    r_tail;
    logic [W_INST-1:0]   r_q_inst [DEPTH];
    logic [W_ADDR-1:0]   r_q_pc   [DEPTH];
    logic [W_INST-1:0]   r_last_inst;
    logic [W_ADDR-1:0]   r_last_pc;

    // Next-state / combinational signals
    state_t              w_state_nxt;
    logic [W_ADDR-1:0]   w_addr_nxt;
    logic [W_ADDR-1:0]   w_fetch_pc_nxt;
    logic [W_CNT-1:0]    w_count_nxt;
    logic [W_CNT-1:0]    w_cnt_after;
    logic [W_PTR-1:0]    w_head_nxt;
    logic [W_PTR-1:0]    w_tail_nxt;
    logic [W_ADDR-1:0]   w_br_pc;
    logic [W_ADDR-1:0]   w_pc_inc;
    logic                w_ack;
    logic                w_valid;
    logic                w_push;
    logic                w_pop;
    logic                w_unused_br_lsb;

    // Target is forced to a word boundary; its low bits carry no meaning.
    assign w_unused_br_lsb = ^br_target_i[1:0];

    always_comb begin
        w_br_pc     = {br_target_i[W_ADDR-1:2], 2'b00};
        w_pc_inc    = r_addr + W_ADDR'(4);
        // An ack only counts while a request is actually open.
        w_ack       = (r_state != S_IDLE) && imem_ack_i;
        w_valid     = (r_count != '0);
        w_pop       = w_valid && !stall_i && !br_valid_i;
        // In DISCARD the returning word belongs to a squashed path.
        w_push      = (r_state == S_REQ) && w_ack && !br_valid_i;
        w_cnt_after = r_count + W_CNT'(w_push) - W_CNT'(w_pop);
    end

    // Queue pointer / occupancy update; a redirect empties the queue and
    // voids any pop in the same cycle.
    always_comb begin
        w_count_nxt = w_cnt_after;
        w_head_nxt  = r_head + W_PTR'(w_pop);
        w_tail_nxt  = r_tail + W_PTR'(w_push);
        if (br_valid_i) begin
            w_count_nxt = '0;
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
        end
    end

    // Fetch FSM next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_fetch_pc_nxt = r_fetch_pc;

        case (r_state)
            S_IDLE: begin
                if (br_valid_i) begin
                    w_fetch_pc_nxt = w_br_pc;
                    w_addr_nxt     = w_br_pc;
                    w_state_nxt    = S_REQ;
                end else if (r_count < C_DEPTH) begin
                    w_addr_nxt  = r_fetch_pc;
                    w_state_nxt = S_REQ;
                end
            end

            S_REQ: begin
                if (br_valid_i) begin
                    w_fetch_pc_nxt = w_br_pc;
                    if (w_ack) begin
                        // Read completes now: drop it and go straight to target.
                        w_addr_nxt = w_br_pc;
                    end else begin
                        // Read still open: address must stay stable until ack.
                        w_state_nxt = S_DISCARD;
                    end
                end else if (w_ack) begin
                    w_fetch_pc_nxt = w_pc_inc;
                    if (w_cnt_after < C_DEPTH) begin
                        w_addr_nxt = w_pc_inc;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_DISCARD: begin
                if (br_valid_i) begin
                    w_fetch_pc_nxt = w_br_pc;
                end
                if (w_ack) begin
                    w_addr_nxt  = br_valid_i ? w_br_pc : r_fetch_pc;
                    w_state_nxt = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= RESET_PC;
            r_fetch_pc  <= RESET_PC;
            r_count     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_last_inst <= '0;
            r_last_pc   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_count    <= w_count_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            // Track the presented head so outputs hold once the queue drains.
            if (w_valid) begin
                r_last_inst <= r_q_inst[r_head];
                r_last_pc   <= r_q_pc[r_head];
            end
        end
    end

    // Queue storage; contents are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_tail] <= imem_data_i;
            r_q_pc[r_tail]   <= r_addr;
        end
    end

    assign imem_req_o   = (r_state != S_IDLE);
    assign imem_addr_o  = r_addr;
    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? r_q_inst[r_head] : r_last_inst;
    assign pc_o         = w_valid ? r_q_pc[r_head]   : r_last_pc;

endmodule
